load_unit: RTL and testbench

//  Load-execute FU that talks to commit_stage's store buffer and data memory.

---
 rtl/load_unit_if.sv | 61 ++++++
 rtl/load_unit.sv | 118 +++++++++++
 tb/tb_load_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/load_unit_if.sv
// rtl/load_unit_if.sv - load_unit issue / store-buffer / memory / write-back bundle
// Purpose: groups every load_unit signal except clock and reset.
// Modports:
//   master - environment side: issue stage, store buffer, data memory, ROB
//   slave  - the load unit itself
// Signal groups:
//   issue_*            load presented by issue, ready back
//   sb_*               store-buffer writeback vector, commit pointer, bypass hit
//   exe_ld_bypass_*    store-buffer bypass lookup
//   exe_mem_*          synchronous data-memory read (1-cycle)
//   exe_w_v_o / exe_*  register write-back; cdb_* ROB completion
//   rob_mispredict_i   flush
interface load_unit_if #(
  parameter int WORD_SIZE_P  = 16,
  parameter int NUM_PHYS_REG = 64,
  parameter int SB_ENTRY     = 8,
  parameter int ROB_ENTRY    = 16
);
  localparam int RW  = $clog2(NUM_PHYS_REG);
  localparam int SBW = $clog2(SB_ENTRY);
  localparam int ROBW = $clog2(ROB_ENTRY);

  logic                   issue_ld_v_i;
  logic                   issue_ld_ready_o;
  logic [WORD_SIZE_P-1:0] issue_base_i;
  logic [5:0]             issue_imm_i;
  logic [RW-1:0]          issue_rd_i;
  logic [ROBW-1:0]        issue_rob_num_i;
  logic                   issue_has_older_st_i;
  logic [SBW-1:0]         issue_sb_num_i;
  logic [SB_ENTRY-1:0]    sb_wb_vector_i;
  logic [SBW-1:0]         sb_commit_pt_i;
  logic [WORD_SIZE_P-1:0] exe_ld_bypass_addr_o;
  logic [SBW-1:0]         exe_ld_bypass_sb_num_o;
  logic                   sb_ld_bypass_valid_i;
  logic [WORD_SIZE_P-1:0] sb_ld_bypass_value_i;
  logic [WORD_SIZE_P-1:0] exe_mem_addr_o;
  logic [WORD_SIZE_P-1:0] exe_mem_data_i;
  logic                   exe_w_v_o;
  logic [RW-1:0]          exe_addr_o;
  logic [WORD_SIZE_P-1:0] exe_data_o;
  logic                   cdb_v_o;
  logic [ROBW-1:0]        cdb_rob_num_o;
  logic                   rob_mispredict_i;

  modport master (
    output issue_ld_v_i, issue_base_i, issue_imm_i, issue_rd_i, issue_rob_num_i,
           issue_has_older_st_i, issue_sb_num_i, sb_wb_vector_i, sb_commit_pt_i,
           sb_ld_bypass_valid_i, sb_ld_bypass_value_i, exe_mem_data_i, rob_mispredict_i,
    input  issue_ld_ready_o, exe_ld_bypass_addr_o, exe_ld_bypass_sb_num_o, exe_mem_addr_o,
           exe_w_v_o, exe_addr_o, exe_data_o, cdb_v_o, cdb_rob_num_o
  );

  modport slave (
    input  issue_ld_v_i, issue_base_i, issue_imm_i, issue_rd_i, issue_rob_num_i,
           issue_has_older_st_i, issue_sb_num_i, sb_wb_vector_i, sb_commit_pt_i,
           sb_ld_bypass_valid_i, sb_ld_bypass_value_i, exe_mem_data_i, rob_mispredict_i,
    output issue_ld_ready_o, exe_ld_bypass_addr_o, exe_ld_bypass_sb_num_o, exe_mem_addr_o,
           exe_w_v_o, exe_addr_o, exe_data_o, cdb_v_o, cdb_rob_num_o
  );
endinterface

// File: rtl/load_unit.sv
// rtl/load_unit.sv - load-execute functional unit with store-buffer ordering and bypass
// Purpose: accepts one load, computes base + sext(imm), waits until every older
//   store-buffer entry has written back, looks up the store-buffer bypass while
//   reading data memory, then writes the register file and completes on the CDB.
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   lu         load_unit_if.slave (issue, store buffer, memory, write-back, flush)
// Sequence: IDLE -> WAIT_ST (>=1 cycle) -> ACCESS -> RESP -> IDLE.
module load_unit #(
  parameter int WORD_SIZE_P  = 16,
  parameter int NUM_PHYS_REG = 64,
  parameter int SB_ENTRY     = 8,
  parameter int ROB_ENTRY    = 16
) (
  input logic       clk_i,
  input logic       reset_n_i,
  load_unit_if.slave lu
);
  localparam int RW   = $clog2(NUM_PHYS_REG);
  localparam int SBW  = $clog2(SB_ENTRY);
  localparam int ROBW = $clog2(ROB_ENTRY);

  typedef enum logic [1:0] {IDLE, WAIT_ST, ACCESS, RESP} state_t;

  state_t                 state_q;
  logic [WORD_SIZE_P-1:0] addr_q;
  logic [RW-1:0]          rd_q;
  logic [ROBW-1:0]        rob_q;
  logic                   has_older_q;
  logic [SBW-1:0]         sb_num_q;
  logic                   hit_q;
  logic [WORD_SIZE_P-1:0] hit_val_q;

  logic [WORD_SIZE_P-1:0] eff_addr;
  logic                   older_done;
  logic                   busy;
  logic                   wb_fire;

  // Membership in the circular range first..last, inclusive on both ends.
  function automatic logic in_older_set(input logic [SBW-1:0] idx,
                                        input logic [SBW-1:0] first,
                                        input logic [SBW-1:0] last);
    if (first <= last) return (idx >= first) && (idx <= last);
    else               return (idx >= first) || (idx <= last);
  endfunction

  assign eff_addr = lu.issue_base_i + {{(WORD_SIZE_P-6){lu.issue_imm_i[5]}}, lu.issue_imm_i};

  // The commit pointer and writeback vector are watched live: the set shrinks
  // as stores commit, so only the latched youngest-older index is frozen.
  always_comb begin
    older_done = 1'b1;
    for (int i = 0; i < SB_ENTRY; i++) begin
      if (has_older_q && in_older_set(SBW'(i), lu.sb_commit_pt_i, sb_num_q) &&
          !lu.sb_wb_vector_i[i])
        older_done = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_q        <= '0;
      rob_q       <= '0;
      has_older_q <= 1'b0;
      sb_num_q    <= '0;
      hit_q       <= 1'b0;
      hit_val_q   <= '0;
    end else if (lu.rob_mispredict_i) begin
      // Flush wins over everything, including a same-cycle issue.
      state_q <= IDLE;
      hit_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lu.issue_ld_v_i) begin
            addr_q      <= eff_addr;
            rd_q        <= lu.issue_rd_i;
            rob_q       <= lu.issue_rob_num_i;
            has_older_q <= lu.issue_has_older_st_i;
            sb_num_q    <= lu.issue_sb_num_i;
            state_q     <= WAIT_ST;
          end
        end
        WAIT_ST: begin
          if (older_done) state_q <= ACCESS;
        end
        ACCESS: begin
          // A bypass hit is meaningless when no older store exists.
          hit_q     <= has_older_q & lu.sb_ld_bypass_valid_i;
          hit_val_q <= lu.sb_ld_bypass_value_i;
          state_q   <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  // Memory data arrives combinationally in RESP, and a flush in that same
  // cycle must cancel the pulse, so the write-back outputs are gated here.
  assign wb_fire = (state_q == RESP) && !lu.rob_mispredict_i;

  assign lu.issue_ld_ready_o       = (state_q == IDLE);
  assign lu.exe_mem_addr_o         = busy ? addr_q : '0;
  assign lu.exe_ld_bypass_addr_o   = busy ? addr_q : '0;
  assign lu.exe_ld_bypass_sb_num_o = busy ? sb_num_q : '0;
  assign lu.exe_w_v_o              = wb_fire;
  assign lu.cdb_v_o                = wb_fire;
  assign lu.exe_addr_o             = wb_fire ? rd_q : '0;
  assign lu.cdb_rob_num_o          = wb_fire ? rob_q : '0;
  assign lu.exe_data_o             = wb_fire ? (hit_q ? hit_val_q : lu.exe_mem_data_i) : '0;
endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - directed self-checking bench for load_unit
module tb_load_unit;
  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] mem_addr_t;
  logic [15:0] mem_val_t;

  load_unit_if bus ();

  load_unit dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .lu        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous one-cycle data memory holding a single programmed word.
  always @(posedge clk)
    bus.exe_mem_data_i <= (bus.exe_mem_addr_o == mem_addr_t) ? mem_val_t : 16'hDEAD;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a load for one cycle; returns with the unit in WAIT_ST.
  task automatic issue(input logic [15:0] base, input logic [5:0] imm, input logic [5:0] rd,
                       input logic [3:0] rob, input logic older, input logic [2:0] sbn);
    bus.issue_ld_v_i         = 1'b1;
    bus.issue_base_i         = base;
    bus.issue_imm_i          = imm;
    bus.issue_rd_i           = rd;
    bus.issue_rob_num_i      = rob;
    bus.issue_has_older_st_i = older;
    bus.issue_sb_num_i       = sbn;
    tick();
    bus.issue_ld_v_i = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.issue_ld_v_i = 0; bus.issue_base_i = 0; bus.issue_imm_i = 0; bus.issue_rd_i = 0;
    bus.issue_rob_num_i = 0; bus.issue_has_older_st_i = 0; bus.issue_sb_num_i = 0;
    bus.sb_wb_vector_i = 0; bus.sb_commit_pt_i = 0; bus.sb_ld_bypass_valid_i = 0;
    bus.sb_ld_bypass_value_i = 0; bus.rob_mispredict_i = 0;
    mem_addr_t = 16'h000E; mem_val_t = 16'hBEEF;
    tick(); tick();
    check("rst_ready", bus.issue_ld_ready_o, 1);
    check("rst_wv", bus.exe_w_v_o, 0);
    check("rst_cdb", bus.cdb_v_o, 0);
    check("rst_memaddr", bus.exe_mem_addr_o, 0);
    check("rst_data", bus.exe_data_o, 0);
    reset_n = 1'b1;
    tick();

    // Basic load, no older store: base 0x0010 + (-2) = 0x000E.
    issue(16'h0010, 6'b111110, 6'd5, 4'd3, 1'b0, 3'd0);
    check("t1_ready_busy", bus.issue_ld_ready_o, 0);
    check("t1_memaddr", bus.exe_mem_addr_o, 16'h000E);
    check("t1_bpaddr", bus.exe_ld_bypass_addr_o, 16'h000E);
    tick();
    check("t1_wv_access", bus.exe_w_v_o, 0);
    tick();
    check("t1_wv", bus.exe_w_v_o, 1);
    check("t1_cdb", bus.cdb_v_o, 1);
    check("t1_data", bus.exe_data_o, 16'hBEEF);
    check("t1_rd", bus.exe_addr_o, 5);
    check("t1_rob", bus.cdb_rob_num_o, 3);
    tick();
    check("t1_wv_after", bus.exe_w_v_o, 0);
    check("t1_data_after", bus.exe_data_o, 0);
    check("t1_ready_after", bus.issue_ld_ready_o, 1);

    // Older stores 1..2; entry 2 writes back after 5 stalled cycles.
    mem_addr_t = 16'h0105; mem_val_t = 16'h5A5A;
    bus.sb_commit_pt_i = 3'd1; bus.sb_wb_vector_i = 8'b0000_0010;
    issue(16'h0100, 6'd5, 6'd7, 4'd4, 1'b1, 3'd2);
    check("t2_sbnum", bus.exe_ld_bypass_sb_num_o, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_stall", {bus.exe_w_v_o, bus.issue_ld_ready_o}, 2'b00);
    end
    bus.sb_wb_vector_i = 8'b0000_0110;
    tick();
    check("t2_access", bus.exe_w_v_o, 0);
    tick();
    check("t2_wv", bus.exe_w_v_o, 1);
    check("t2_data", bus.exe_data_o, 16'h5A5A);
    check("t2_rob", bus.cdb_rob_num_o, 4);
    tick();

    // Wrapped older set 6,7,0,1 fully written back: no stall.
    mem_addr_t = 16'h0300; mem_val_t = 16'h0A0A;
    bus.sb_commit_pt_i = 3'd6; bus.sb_wb_vector_i = 8'b1100_0011;
    issue(16'h0300, 6'd0, 6'd1, 4'd1, 1'b1, 3'd1);
    tick();
    check("t3_access", bus.exe_w_v_o, 0);
    tick();
    check("t3_wv", bus.exe_w_v_o, 1);
    check("t3_data", bus.exe_data_o, 16'h0A0A);
    tick();

    // Same wrap with entry 7 pending: must stall until it arrives.
    bus.sb_wb_vector_i = 8'b0100_0011;
    issue(16'h0300, 6'd0, 6'd2, 4'd2, 1'b1, 3'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_stall", bus.exe_w_v_o, 0);
    end
    bus.sb_wb_vector_i = 8'b1100_0011;
    tick();
    check("t4_access", bus.exe_w_v_o, 0);
    tick();
    check("t4_wv", bus.exe_w_v_o, 1);
    check("t4_rob", bus.cdb_rob_num_o, 2);
    tick();

    // Store-buffer hit overrides memory.
    mem_addr_t = 16'h0200; mem_val_t = 16'hFFFF;
    bus.sb_commit_pt_i = 3'd3; bus.sb_wb_vector_i = 8'b0000_1000;
    bus.sb_ld_bypass_valid_i = 1'b1; bus.sb_ld_bypass_value_i = 16'h1234;
    issue(16'h0200, 6'd0, 6'd42, 4'd9, 1'b1, 3'd3);
    tick(); tick();
    check("t5_wv", bus.exe_w_v_o, 1);
    check("t5_data_hit", bus.exe_data_o, 16'h1234);
    check("t5_rob", bus.cdb_rob_num_o, 9);
    check("t5_rd", bus.exe_addr_o, 42);
    tick();

    // Hit flag ignored when there is no older store.
    issue(16'h0200, 6'd0, 6'd43, 4'd10, 1'b0, 3'd3);
    tick(); tick();
    check("t6_data_nohit", bus.exe_data_o, 16'hFFFF);
    tick();
    bus.sb_ld_bypass_valid_i = 1'b0;

    // Flush in RESP suppresses write-back.
    issue(16'h0200, 6'd0, 6'd8, 4'd5, 1'b0, 3'd0);
    tick(); tick();
    bus.rob_mispredict_i = 1'b1;
    #1;
    check("t7_wv_flush", bus.exe_w_v_o, 0);
    check("t7_cdb_flush", bus.cdb_v_o, 0);
    check("t7_data_flush", bus.exe_data_o, 0);
    tick();
    bus.rob_mispredict_i = 1'b0;
    check("t7_ready", bus.issue_ld_ready_o, 1);

    // Issue in the flush cycle is dropped.
    bus.rob_mispredict_i = 1'b1;
    issue(16'h0200, 6'd0, 6'd8, 4'd5, 1'b0, 3'd0);
    bus.rob_mispredict_i = 1'b0;
    check("t8_ready", bus.issue_ld_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t8_nopulse", bus.exe_w_v_o, 0);
    end

    // Address wrap: 0xFFFF + 1 = 0x0000.
    mem_addr_t = 16'h0000; mem_val_t = 16'h7777;
    issue(16'hFFFF, 6'd1, 6'd9, 4'd6, 1'b0, 3'd0);
    check("t9_memaddr", bus.exe_mem_addr_o, 16'h0000);
    check("t9_busy", bus.issue_ld_ready_o, 0);
    tick(); tick();
    check("t9_data", bus.exe_data_o, 16'h7777);
    tick();

    // Async reset while stalled in WAIT_ST.
    bus.sb_commit_pt_i = 3'd0; bus.sb_wb_vector_i = 8'b0000_0000;
    issue(16'h0400, 6'd4, 6'd11, 4'd7, 1'b1, 3'd5);
    check("t10_memaddr_wait", bus.exe_mem_addr_o, 16'h0404);
    check("t10_sbnum_wait", bus.exe_ld_bypass_sb_num_o, 5);
    reset_n = 1'b0;
    #1;
    check("t10_ready", bus.issue_ld_ready_o, 1);
    check("t10_memaddr", bus.exe_mem_addr_o, 0);
    check("t10_sbnum", bus.exe_ld_bypass_sb_num_o, 0);
    check("t10_wv", bus.exe_w_v_o, 0);
    tick();
    reset_n = 1'b1;
    bus.sb_wb_vector_i = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t10_nopulse", bus.exe_w_v_o, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
